poly_commutator: RTL and testbench
==================================

Name: poly_commutator

Overview:
Parametrised polyphase commutator. Replaces the derived-clock commutator with a single-clock, enable-paced design. Supports both modes:
- mode 0, parallel-to-serial (interpolator output);
- mode 1, serial-to-parallel (decimator input).
Adds runtime direction and phase selection, a valid/ready handshake and frame markers. Sits between the polyphase sub-filter bank and the stream datapath.

Parameters:
gp_idata_width, 16, width of one sample (W)
gp_nr_phases, 4, number of polyphase channels N (>=2, need not be a power of 2)
gp_mode, 0, 0 = parallel-to-serial, 1 = serial-to-parallel

Ports:
i_clk  in  1  rising-edge clock
i_rst_an  in  1  asynchronous active-low reset
i_ena  in  1  synchronous active-high clock enable; all state frozen when low
i_ccw  in  1  direction: 1 = counter-clockwise (ascending slots), 0 = clockwise (descending slots)
i_phase  in  clog2(N)  starting phase offset
i_valid  in  1  input sample/word valid
o_ready  out  1  block can accept input this cycle
i_data  in  mode0: N*W, mode1: W  signed input; slot k = bits [(k+1)*W-1 : k*W]
o_data  out  mode0: W, mode1: N*W  signed output
o_valid  out  1  o_data valid
o_sof  out  1  first beat of a frame (mode 0) / unused 0 (mode 1)
o_eof  out  1  last beat (mode 0) / frame-complete pulse (mode 1)
o_ovf  out  1  overflow flag (see Optional Feature)

Behaviour:
- Reset: o_data=0, o_valid=0, o_sof=0, o_eof=0, o_ovf=0, o_ready=1 (mode 0) / 1 (mode 1); index=0, state IDLE.
- An accept occurs in a cycle where i_ena & i_valid & o_ready. With i_ena=0, nothing advances and outputs hold.
- Start slot, computed at frame start only:
  - CCW: start = i_phase;
  - CW: start = N-1-i_phase.
  - i_phase >= N is treated as 0.
  - Slot order: CCW increments, CW decrements; both wrap modulo N (N-1 -> 0, 0 -> N-1).
- i_ccw and i_phase are sampled only when a frame starts. Changes mid-frame are ignored.
- Mode 0 FSM, states IDLE and RUN:
  - IDLE: o_ready=1, o_valid=0. Accept -> latch i_data into the hold register, slot=start, beat=0, go to RUN.
  - RUN: each enabled cycle, o_data = hold[slot], o_valid=1, o_sof=(beat==0), o_eof=(beat==N-1); slot steps, beat++.
  - Latency: first output beat appears the cycle after the accept.
  - o_ready=1 only on the last beat (beat==N-1). An accept on that beat reloads the hold register and the next frame follows with no gap (seamless back-to-back). Otherwise return to IDLE.
  - i_valid while o_ready=0: input is dropped, no other effect.
- Mode 1:
  - o_ready is always 1.
  - Each accept writes i_data into the shadow slot, steps slot and beat.
  - On the N-th accept, copy the shadow (with the current write) to o_data; o_valid=1 and o_eof=1 the following cycle for one cycle, then beat=0.
  - o_data holds until the next frame completes.
- Reset mid-frame: frame discarded, returns to reset state; no partial output.

Optional Feature:
Macro POLY_COMMUTATOR_OVF_DET_EN.
- Defined: o_ovf is set on any cycle with i_ena & i_valid & ~o_ready (mode 0) and stays set until reset. In mode 1, it is set when i_valid is asserted with i_ena low.
- Undefined: o_ovf is tied to 0 and no detection logic is generated.

Decomposition:
- Package poly_commutator_pkg holds:
  - mode constants C_MODE_P2S=0, C_MODE_S2P=1;
  - direction constants;
  - state enum (IDLE, RUN);
  - function f_start_slot(ccw, phase, N);
  - function f_next_slot(slot, ccw, N);
  - c_idx_width = clog2(N).
- Sub-module poly_commutator_idx: slot/beat counter with direction, phase load and modulo-N wrap. It is shared by both modes.

Test Plan:
1. Mode 0, N=4, W=4, CW, phase 0; accept i_data=16'h4321 at cycle t -> o_data 4,3,2,1 at t+1..t+4; o_sof at t+1, o_eof at t+4.
2. Mode 0, CCW, phase 1, i_data=16'h4321 -> o_data 2,3,4,1; then i_valid held with 16'h8765 -> 6,7,8,5 with no idle cycle between frames.
3. Mode 0, i_ena low for 3 cycles after beat 1 -> o_data/o_valid hold for 3 cycles, then the sequence resumes with no beat lost. With POLY_COMMUTATOR_OVF_DET_EN, i_valid on beat 1 -> o_ovf=1 sticky.
4. Mode 1, N=4, CCW, phase 0, serial 1,2,3,4 -> o_data=16'h4321, o_valid/o_eof one cycle after the 4th accept. CW phase 0 on the same input -> 16'h1234.
5. N=3 (non-power-of-2), mode 0, CW, phase 2, i_data=12'h321 -> o_data 1,3,2 (wrap 0 -> 2).
6. i_rst_an asserted mid-frame (beat 2) -> all outputs 0 immediately; after release, the next accept starts a fresh frame at the start slot.

Source files
------------

// File: rtl/poly_commutator_pkg.sv
// ----------------------------------------------------------------------------
// poly_commutator_pkg
// Shared constants, state encoding and slot arithmetic for the polyphase
// commutator (mode selection, direction codes, start/next slot helpers).
// Revision: 1.0 - initial single-clock, enable-paced release
// ----------------------------------------------------------------------------
`default_nettype none

package poly_commutator_pkg;

  // Commutation modes
  localparam int C_MODE_P2S = 0;  // parallel-to-serial (interpolator output)
  localparam int C_MODE_S2P = 1;  // serial-to-parallel (decimator input)

  // Direction codes carried on i_ccw
  localparam logic C_DIR_CW  = 1'b0;  // descending slots
  localparam logic C_DIR_CCW = 1'b1;  // ascending slots

  // Parallel-to-serial frame state
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Slot/beat index width for N phases: clog2(N), never below one bit
  function automatic int f_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First slot of a frame; an out-of-range phase falls back to zero
  function automatic int f_start_slot(input logic ccw, input int phase, input int n);
    int p;
    p = (phase >= n) ? 0 : phase;
    return (ccw == C_DIR_CCW) ? p : (n - 1 - p);
  endfunction

  // Following slot in the chosen direction, wrapping modulo N
  function automatic int f_next_slot(input int slot, input logic ccw, input int n);
    if (ccw == C_DIR_CCW) begin
      return (slot >= n - 1) ? 0 : slot + 1;
    end
    return (slot == 0) ? n - 1 : slot - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/poly_commutator_idx.sv
// ----------------------------------------------------------------------------
// poly_commutator_idx
// Slot/beat counter for the commutator. A load latches direction and the
// phase-derived start slot; a step advances slot (modulo N, either direction)
// and beat. Load and step may coincide: the step then starts from the freshly
// loaded start slot, which is what the serial-to-parallel path needs on the
// first word of a frame. Next-state values are exported so the caller can
// register its outputs in the same cycle the index moves.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module poly_commutator_idx
  import poly_commutator_pkg::*;
#(
  parameter int gp_nr_phases = 4
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_an,
  input  logic                                  i_ena,
  input  logic                                  i_load,
  input  logic                                  i_step,
  input  logic                                  i_ccw,
  input  logic [f_idx_width(gp_nr_phases)-1:0]  i_phase,
  output logic [f_idx_width(gp_nr_phases)-1:0]  o_beat,
  output logic                                  o_last,
  output logic [f_idx_width(gp_nr_phases)-1:0]  o_wr_slot,
  output logic [f_idx_width(gp_nr_phases)-1:0]  o_slot_nxt,
  output logic [f_idx_width(gp_nr_phases)-1:0]  o_beat_nxt
);

  localparam int c_idx_width = f_idx_width(gp_nr_phases);
  localparam logic [c_idx_width-1:0] c_last = c_idx_width'(gp_nr_phases - 1);

  logic [c_idx_width-1:0] r_slot;
  logic [c_idx_width-1:0] r_beat;
  logic                   r_ccw;

  logic [c_idx_width-1:0] w_start;
  logic [c_idx_width-1:0] w_base_slot;
  logic [c_idx_width-1:0] w_base_beat;
  logic                   w_base_ccw;
  logic [c_idx_width-1:0] w_slot_nxt;
  logic [c_idx_width-1:0] w_beat_nxt;

  // Next index: optional reload to the start slot, then optional step
  always_comb begin
    w_start     = c_idx_width'(f_start_slot(i_ccw, int'(i_phase), gp_nr_phases));
    w_base_slot = i_load ? w_start : r_slot;
    w_base_beat = i_load ? '0 : r_beat;
    w_base_ccw  = i_load ? i_ccw : r_ccw;
    w_slot_nxt  = w_base_slot;
    w_beat_nxt  = w_base_beat;
    if (i_step) begin
      w_slot_nxt = c_idx_width'(f_next_slot(int'(w_base_slot), w_base_ccw, gp_nr_phases));
      w_beat_nxt = (w_base_beat == c_last) ? '0 : w_base_beat + 1'b1;
    end
  end

  // Index registers, frozen while the enable is low
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      r_slot <= '0;
      r_beat <= '0;
      r_ccw  <= C_DIR_CW;
    end else if (i_ena) begin
      r_slot <= w_slot_nxt;
      r_beat <= w_beat_nxt;
      r_ccw  <= w_base_ccw;
    end
  end

  assign o_beat     = r_beat;
  assign o_last     = (r_beat == c_last);
  assign o_wr_slot  = w_base_slot;
  assign o_slot_nxt = w_slot_nxt;
  assign o_beat_nxt = w_beat_nxt;

endmodule

`default_nettype wire

// File: rtl/poly_commutator.sv
// ----------------------------------------------------------------------------
// poly_commutator
// Single-clock, enable-paced polyphase commutator.
//   gp_mode 0: parallel-to-serial, one N-sample word in, N serial beats out
//              with o_sof/o_eof markers and seamless back-to-back frames.
//   gp_mode 1: serial-to-parallel, N serial samples in, one N-sample word
//              out with a one-cycle o_valid/o_eof pulse.
// Direction (i_ccw) and start phase (i_phase) are sampled at frame start.
// Optional: define POLY_COMMUTATOR_OVF_DET_EN for a sticky overflow flag.
// Revision: 1.0 - initial single-clock, enable-paced release
// ----------------------------------------------------------------------------
`default_nettype none

module poly_commutator
  import poly_commutator_pkg::*;
#(
  parameter int gp_idata_width = 16,
  parameter int gp_nr_phases   = 4,
  parameter int gp_mode        = 0
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_an,
  input  logic                                 i_ena,
  input  logic                                 i_ccw,
  input  logic [f_idx_width(gp_nr_phases)-1:0] i_phase,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  input  logic signed [((gp_mode == C_MODE_P2S) ? gp_nr_phases*gp_idata_width
                                                : gp_idata_width)-1:0] i_data,
  output logic signed [((gp_mode == C_MODE_P2S) ? gp_idata_width
                                                : gp_nr_phases*gp_idata_width)-1:0] o_data,
  output logic                                 o_valid,
  output logic                                 o_sof,
  output logic                                 o_eof,
  output logic                                 o_ovf
);

  localparam int c_idx_width = f_idx_width(gp_nr_phases);
  localparam int c_nw        = gp_nr_phases * gp_idata_width;
  localparam logic [c_idx_width-1:0] c_last = c_idx_width'(gp_nr_phases - 1);

  logic                   w_load;
  logic                   w_step;
  logic [c_idx_width-1:0] w_beat;
  logic                   w_last;
  logic [c_idx_width-1:0] w_wr_slot;
  logic [c_idx_width-1:0] w_slot_nxt;
  logic [c_idx_width-1:0] w_beat_nxt;

  poly_commutator_idx #(
    .gp_nr_phases (gp_nr_phases)
  ) u_idx (
    .i_clk      (i_clk),
    .i_rst_an   (i_rst_an),
    .i_ena      (i_ena),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_ccw      (i_ccw),
    .i_phase    (i_phase),
    .o_beat     (w_beat),
    .o_last     (w_last),
    .o_wr_slot  (w_wr_slot),
    .o_slot_nxt (w_slot_nxt),
    .o_beat_nxt (w_beat_nxt)
  );

  if (gp_mode == C_MODE_P2S) begin : g_p2s

    state_e                    r_state;
    logic [c_nw-1:0]           r_hold;
    logic [gp_idata_width-1:0] r_data;
    logic                      r_valid;
    logic                      r_sof;
    logic                      r_eof;
    logic                      r_ready;

    logic                      w_accept;
    state_e                    w_state_nxt;
    logic                      w_run_nxt;
    logic [c_nw-1:0]           w_hold_nxt;
    logic                      w_unused;

    assign w_accept = i_ena & i_valid & r_ready;
    // A fresh frame reloads the index; otherwise the index walks while RUN
    assign w_load   = w_accept;
    assign w_step   = (r_state == S_RUN) & ~w_accept;

    // Next frame state and hold contents
    always_comb begin
      w_hold_nxt  = w_accept ? i_data : r_hold;
      w_state_nxt = r_state;
      if (w_accept) begin
        w_state_nxt = S_RUN;
      end else if ((r_state == S_RUN) && w_last) begin
        w_state_nxt = S_IDLE;
      end
      w_run_nxt = (w_state_nxt == S_RUN);
    end

    // Frame FSM; outputs are registered so they describe the beat being shown
    always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
        r_state <= S_IDLE;
        r_hold  <= '0;
        r_data  <= '0;
        r_valid <= 1'b0;
        r_sof   <= 1'b0;
        r_eof   <= 1'b0;
        r_ready <= 1'b1;
      end else if (i_ena) begin
        r_state <= w_state_nxt;
        r_hold  <= w_hold_nxt;
        r_data  <= w_run_nxt ? w_hold_nxt[int'(w_slot_nxt)*gp_idata_width +: gp_idata_width]
                             : '0;
        r_valid <= w_run_nxt;
        r_sof   <= w_run_nxt & (w_beat_nxt == '0);
        r_eof   <= w_run_nxt & (w_beat_nxt == c_last);
        r_ready <= ~w_run_nxt | (w_beat_nxt == c_last);
      end
    end

    assign o_data   = r_data;
    assign o_valid  = r_valid;
    assign o_sof    = r_sof;
    assign o_eof    = r_eof;
    assign o_ready  = r_ready;
    assign w_unused = &{1'b0, w_wr_slot, w_beat};

`ifdef POLY_COMMUTATOR_OVF_DET_EN
    logic r_ovf;

    // Sticky flag: a word offered while a frame is still being serialised
    always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
        r_ovf <= 1'b0;
      end else if (i_ena & i_valid & ~r_ready) begin
        r_ovf <= 1'b1;
      end
    end

    assign o_ovf = r_ovf;
`else
    assign o_ovf = 1'b0;
`endif

  end else begin : g_s2p

    logic [c_nw-1:0] r_shadow;
    logic [c_nw-1:0] r_data;
    logic            r_valid;
    logic            r_eof;

    logic            w_accept;
    logic            w_frame_done;
    logic [c_nw-1:0] w_shadow_nxt;
    logic            w_unused;

    assign w_accept     = i_ena & i_valid;
    // The first word of a frame samples direction/phase and writes the start slot
    assign w_load       = w_accept & (w_beat == '0);
    assign w_step       = w_accept;
    assign w_frame_done = w_accept & w_last;

    // Shadow image including the word being accepted this cycle
    always_comb begin
      w_shadow_nxt = r_shadow;
      if (w_accept) begin
        w_shadow_nxt[int'(w_wr_slot)*gp_idata_width +: gp_idata_width] = i_data;
      end
    end

    // Collect samples and publish the full word once the frame completes
    always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
        r_shadow <= '0;
        r_data   <= '0;
        r_valid  <= 1'b0;
        r_eof    <= 1'b0;
      end else if (i_ena) begin
        r_shadow <= w_shadow_nxt;
        r_valid  <= w_frame_done;
        r_eof    <= w_frame_done;
        if (w_frame_done) begin
          r_data <= w_shadow_nxt;
        end
      end
    end

    assign o_data   = r_data;
    assign o_valid  = r_valid;
    assign o_sof    = 1'b0;
    assign o_eof    = r_eof;
    assign o_ready  = 1'b1;
    assign w_unused = &{1'b0, w_slot_nxt, w_beat_nxt};

`ifdef POLY_COMMUTATOR_OVF_DET_EN
    logic r_ovf;

    // Sticky flag: a sample offered while the block is stalled
    always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
        r_ovf <= 1'b0;
      end else if (i_valid & ~i_ena) begin
        r_ovf <= 1'b1;
      end
    end

    assign o_ovf = r_ovf;
`else
    assign o_ovf = 1'b0;
`endif

  end

endmodule

`default_nettype wire

// File: tb/tb_poly_commutator.sv
// ----------------------------------------------------------------------------
// tb_poly_commutator
// Scoreboard bench: three instances (P2S N=4, S2P N=4, P2S N=3, all W=4).
// Stimulus pushes hand-computed expected beats; per-instance monitors pop
// and compare whenever an instance presents an enabled valid output.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_poly_commutator;

`ifdef POLY_COMMUTATOR_OVF_DET_EN
  localparam logic c_ovf_exp = 1'b1;
`else
  localparam logic c_ovf_exp = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] d;
    logic       sof;
    logic       eof;
  } beat_t;

  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  logic rst_an;
  always #5 clk = ~clk;

  // Instance A: P2S, N=4
  logic a_ena, a_ccw, a_valid, a_ready, a_ovalid, a_osof, a_oeof, a_oovf;
  logic [1:0]  a_phase;
  logic [15:0] a_data;
  logic [3:0]  a_odata;
  // Instance B: S2P, N=4
  logic b_ena, b_ccw, b_valid, b_ready, b_ovalid, b_osof, b_oeof, b_oovf;
  logic [1:0]  b_phase;
  logic [3:0]  b_data;
  logic [15:0] b_odata;
  // Instance C: P2S, N=3
  logic c_ena, c_ccw, c_valid, c_ready, c_ovalid, c_osof, c_oeof, c_oovf;
  logic [1:0]  c_phase;
  logic [11:0] c_data;
  logic [3:0]  c_odata;

  beat_t       qa[$];
  beat_t       qc[$];
  logic [15:0] qb[$];

  poly_commutator #(.gp_idata_width(4), .gp_nr_phases(4), .gp_mode(0)) u_a (
    .i_clk(clk), .i_rst_an(rst_an), .i_ena(a_ena), .i_ccw(a_ccw), .i_phase(a_phase),
    .i_valid(a_valid), .o_ready(a_ready), .i_data(a_data), .o_data(a_odata),
    .o_valid(a_ovalid), .o_sof(a_osof), .o_eof(a_oeof), .o_ovf(a_oovf));

  poly_commutator #(.gp_idata_width(4), .gp_nr_phases(4), .gp_mode(1)) u_b (
    .i_clk(clk), .i_rst_an(rst_an), .i_ena(b_ena), .i_ccw(b_ccw), .i_phase(b_phase),
    .i_valid(b_valid), .o_ready(b_ready), .i_data(b_data), .o_data(b_odata),
    .o_valid(b_ovalid), .o_sof(b_osof), .o_eof(b_oeof), .o_ovf(b_oovf));

  poly_commutator #(.gp_idata_width(4), .gp_nr_phases(3), .gp_mode(0)) u_c (
    .i_clk(clk), .i_rst_an(rst_an), .i_ena(c_ena), .i_ccw(c_ccw), .i_phase(c_phase),
    .i_valid(c_valid), .o_ready(c_ready), .i_data(c_data), .o_data(c_odata),
    .o_valid(c_ovalid), .o_sof(c_osof), .o_eof(c_oeof), .o_ovf(c_oovf));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_a(input logic [3:0] e0, input logic [3:0] e1,
                        input logic [3:0] e2, input logic [3:0] e3);
    qa.push_back('{e0, 1'b1, 1'b0});
    qa.push_back('{e1, 1'b0, 1'b0});
    qa.push_back('{e2, 1'b0, 1'b0});
    qa.push_back('{e3, 1'b0, 1'b1});
  endtask

  task automatic push_c(input logic [3:0] e0, input logic [3:0] e1, input logic [3:0] e2);
    qc.push_back('{e0, 1'b1, 1'b0});
    qc.push_back('{e1, 1'b0, 1'b0});
    qc.push_back('{e2, 1'b0, 1'b1});
  endtask

  // Offer one word to A and hold it until accepted (bounded)
  task automatic a_send(input logic [15:0] d, input logic ccw, input logic [1:0] ph);
    int n;
    n = 0;
    a_data = d; a_ccw = ccw; a_phase = ph; a_valid = 1'b1;
    @(negedge clk);
    while (a_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("a_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic c_send(input logic [11:0] d, input logic ccw, input logic [1:0] ph);
    int n;
    n = 0;
    c_data = d; c_ccw = ccw; c_phase = ph; c_valid = 1'b1;
    @(negedge clk);
    while (c_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("c_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    c_valid = 1'b0;
  endtask

  task automatic b_word(input logic [3:0] d);
    b_data = d; b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
  endtask

  // Monitors: compare each enabled valid output against the scoreboard
  always @(negedge clk) begin
    if (rst_an && a_ena && a_ovalid) begin
      if (qa.size() == 0) check("a_unexpected_beat", 32'd1, 32'd0);
      else begin
        beat_t e;
        e = qa.pop_front();
        check("a_data", a_odata, e.d);
        check("a_sof", a_osof, e.sof);
        check("a_eof", a_oeof, e.eof);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_an && b_ena && b_ovalid) begin
      if (qb.size() == 0) check("b_unexpected_word", 32'd1, 32'd0);
      else begin
        logic [15:0] e;
        e = qb.pop_front();
        check("b_data", b_odata, e);
        check("b_eof", b_oeof, 1'b1);
        check("b_sof", b_osof, 1'b0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_an && c_ena && c_ovalid) begin
      if (qc.size() == 0) check("c_unexpected_beat", 32'd1, 32'd0);
      else begin
        beat_t e;
        e = qc.pop_front();
        check("c_data", c_odata, e.d);
        check("c_sof", c_osof, e.sof);
        check("c_eof", c_oeof, e.eof);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_an = 1'b0;
    a_ena = 1'b1; a_ccw = 1'b0; a_valid = 1'b0; a_phase = '0; a_data = '0;
    b_ena = 1'b1; b_ccw = 1'b0; b_valid = 1'b0; b_phase = '0; b_data = '0;
    c_ena = 1'b1; c_ccw = 1'b0; c_valid = 1'b0; c_phase = '0; c_data = '0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_a_data", a_odata, 4'h0);
    check("rst_a_valid", a_ovalid, 1'b0);
    check("rst_a_sof", a_osof, 1'b0);
    check("rst_a_eof", a_oeof, 1'b0);
    check("rst_a_ovf", a_oovf, 1'b0);
    check("rst_a_ready", a_ready, 1'b1);
    check("rst_b_ready", b_ready, 1'b1);
    check("rst_b_valid", b_ovalid, 1'b0);
    check("rst_b_data", b_odata, 16'h0);
    check("rst_c_ready", c_ready, 1'b1);
    @(negedge clk);
    rst_an = 1'b1;
    @(posedge clk); #1;

    // 1: CW phase 0 -> 4,3,2,1, first beat the cycle after accept
    push_a(4'h4, 4'h3, 4'h2, 4'h1);
    a_send(16'h4321, 1'b0, 2'd0);
    @(negedge clk);
    check("t1_first_valid", a_ovalid, 1'b1);
    check("t1_first_sof", a_osof, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t1_last_eof", a_oeof, 1'b1);
    check("t1_last_ready", a_ready, 1'b1);
    @(negedge clk);
    check("t1_idle_valid", a_ovalid, 1'b0);
    check("t1_ovf_clear", a_oovf, 1'b0);
    @(posedge clk); #1;

    // 2: CCW phase 1 -> 2,3,4,1 then seamless 6,7,8,5
    push_a(4'h2, 4'h3, 4'h4, 4'h1);
    push_a(4'h6, 4'h7, 4'h8, 4'h5);
    a_send(16'h4321, 1'b1, 2'd1);
    a_send(16'h8765, 1'b1, 2'd1);
    @(negedge clk);
    check("t2_b2b_valid", a_ovalid, 1'b1);
    check("t2_b2b_sof", a_osof, 1'b1);
    repeat (5) @(posedge clk); #1;
    check("t2_ovf", a_oovf, c_ovf_exp);

    // 3: stall after beat 1, dropped word while busy
    push_a(4'h4, 4'h3, 4'h2, 4'h1);
    a_send(16'h4321, 1'b0, 2'd0);
    @(posedge clk); #1;
    a_valid = 1'b1; a_data = 16'hFFFF;
    @(posedge clk); #1;
    a_valid = 1'b0; a_ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_hold_data", a_odata, 4'h2);
      check("t3_hold_valid", a_ovalid, 1'b1);
      @(posedge clk); #1;
    end
    a_ena = 1'b1;
    check("t3_ovf", a_oovf, c_ovf_exp);
    repeat (4) @(posedge clk); #1;
    check("t3_ovf_sticky", a_oovf, c_ovf_exp);

    // 4: S2P CCW phase 0 -> 4321; CW phase 0 -> 1234, mid-frame direction change ignored
    b_ccw = 1'b1; b_phase = 2'd0;
    qb.push_back(16'h4321);
    b_word(4'h1); b_word(4'h2); b_word(4'h3); b_word(4'h4);
    @(negedge clk);
    check("t4_valid_pulse", b_ovalid, 1'b1);
    check("t4_eof_pulse", b_oeof, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_valid_end", b_ovalid, 1'b0);
    check("t4_eof_end", b_oeof, 1'b0);
    check("t4_data_hold", b_odata, 16'h4321);
    @(posedge clk); #1;
    b_ccw = 1'b0; b_phase = 2'd0;
    qb.push_back(16'h1234);
    b_word(4'h1);
    b_ccw = 1'b1; b_phase = 2'd2;
    b_word(4'h2); b_word(4'h3); b_word(4'h4);
    @(negedge clk);
    check("t4_cw_valid", b_ovalid, 1'b1);
    check("t4_ovf", b_oovf, 1'b0);
    @(posedge clk); #1;

    // 5: N=3 CW phase 2 -> 1,3,2; CCW phase 3 (out of range -> 0) -> 1,2,3
    push_c(4'h1, 4'h3, 4'h2);
    c_send(12'h321, 1'b0, 2'd2);
    repeat (4) @(posedge clk); #1;
    push_c(4'h1, 4'h2, 4'h3);
    c_send(12'h321, 1'b1, 2'd3);
    repeat (4) @(posedge clk); #1;

    // 6: reset at beat 2, then a fresh CW phase 1 frame -> 7,6,5,8
    push_a(4'h1, 4'h2, 4'h3, 4'h4);
    a_send(16'h4321, 1'b1, 2'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_an = 1'b0;
    qa.delete();
    #1;
    check("t6_rst_data", a_odata, 4'h0);
    check("t6_rst_valid", a_ovalid, 1'b0);
    check("t6_rst_sof", a_osof, 1'b0);
    check("t6_rst_eof", a_oeof, 1'b0);
    check("t6_rst_ovf", a_oovf, 1'b0);
    check("t6_rst_ready", a_ready, 1'b1);
    @(negedge clk);
    rst_an = 1'b1;
    @(posedge clk); #1;
    push_a(4'h7, 4'h6, 4'h5, 4'h8);
    a_send(16'h8765, 1'b0, 2'd1);
    @(negedge clk);
    check("t6_fresh_sof", a_osof, 1'b1);
    repeat (6) @(posedge clk); #1;

    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    check("qc_drained", qc.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
